// File: rtl/imm_rot_encoder_if.sv
// imm_rot_encoder_if: start/value request and busy/done/ok/enc result bundle for imm_rot_encoder
interface imm_rot_encoder_if;
  logic start;
  logic [31:0] value;
  logic busy;
  logic done;
  logic ok;
  logic [11:0] enc;
  modport master (output start, value, input busy, done, ok, enc);
  modport slave (input start, value, output busy, done, ok, enc);
endinterface

// File: rtl/imm_rot_encoder.sv
// imm_rot_encoder: searches one even rotation per cycle for {rot, imm8} with ROR(imm8, 2*rot) == value (ports clk, reset, bus: start/value in, busy/done/ok/enc out)
module imm_rot_encoder (
  input logic clk,
  input logic reset,
  imm_rot_encoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
  state_t state, state_n;
  logic [31:0] v;
  logic [3:0] rot;
  logic ok;
  logic [11:0] enc;
  logic [63:0] dd;
  logic [31:0] c;
  logic hit;
  always_comb begin
    dd = {v, v} << {rot, 1'b0};
    c = dd[63:32];
    hit = c[31:8] == 24'd0;
    state_n = state == IDLE ? (bus.start ? SEARCH : IDLE) :
              state == SEARCH ? ((hit || rot == 4'd15) ? DONE : SEARCH) : IDLE;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      rot <= '0;
      ok <= 1'b0;
      enc <= '0;
    end else if (state == IDLE && bus.start) begin
      v <= bus.value;
      rot <= '0;
    end else if (state == SEARCH) begin
      if (hit) begin
        ok <= 1'b1;
        enc <= {rot, c[7:0]};
      end else if (rot == 4'd15) begin
        ok <= 1'b0;
        enc <= '0;
      end else rot <= rot + 4'd1;
    end
  end
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.ok = ok;
  assign bus.enc = enc;
endmodule

// File: tb/tb_imm_rot_encoder.sv
// tb_imm_rot_encoder: directed and random checks of imm_rot_encoder against a search-by-arithmetic reference
module tb_imm_rot_encoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int passes = 0;
  imm_rot_encoder_if bus();
  imm_rot_encoder dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic void model(input logic [31:0] val, output logic eok, output logic [11:0] eenc, output int elat);
    logic [63:0] t;
    logic [31:0] x;
    eok = 1'b0;
    eenc = '0;
    elat = 17;
    for (int r = 0; r < 16; r++) begin
      t = {32'b0, val} << (2 * r);
      x = t[31:0] | t[63:32];
      if (x < 256) begin
        eok = 1'b1;
        eenc = {r[3:0], x[7:0]};
        elat = r + 2;
        break;
      end
    end
  endfunction
  task automatic run(input logic [31:0] val, input string tag, input logic eok, input logic [11:0] eenc, input int elat);
    int k;
    logic [63:0] t;
    bus.start = 1'b1;
    bus.value = val;
    tick;
    bus.start = 1'b0;
    bus.value = $urandom;
    k = 1;
    chk({tag, " busy"}, bus.busy, 1);
    while (bus.done !== 1'b1 && k < 30) begin
      tick;
      k++;
    end
    chk({tag, " latency"}, k, elat);
    chk({tag, " busy_at_done"}, bus.busy, 1);
    chk({tag, " ok"}, bus.ok, eok);
    chk({tag, " enc"}, bus.enc, eenc);
    if (bus.ok === 1'b1) begin
      t = {24'b0, bus.enc[7:0], 32'b0} >> (2 * bus.enc[11:8]);
      chk({tag, " identity"}, t[63:32] | t[31:0], val);
    end
    tick;
    chk({tag, " busy_after"}, bus.busy, 0);
    chk({tag, " done_after"}, bus.done, 0);
  endtask
  initial begin
    logic eok;
    logic [11:0] eenc;
    int elat;
    int k;
    logic [31:0] val;
    logic [63:0] t;
    bus.start = 1'b1;
    bus.value = 32'hFF;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("rst busy", bus.busy, 0);
      chk("rst done", bus.done, 0);
      chk("rst ok", bus.ok, 0);
      chk("rst enc", bus.enc, 0);
    end
    reset = 1'b0;
    bus.start = 1'b0;
    tick;
    chk("post_rst busy", bus.busy, 0);
    run(32'h000000FF, "direct", 1'b1, 12'h0FF, 2);
    run(32'h00000000, "zero", 1'b1, 12'h000, 2);
    run(32'hFF000000, "rot4", 1'b1, 12'h4FF, 6);
    run(32'hF000000F, "rot2", 1'b1, 12'h2FF, 4);
    run(32'h000003FC, "rot15", 1'b1, 12'hFFF, 17);
    run(32'h00000102, "nofit", 1'b0, 12'h000, 17);
    run(32'h00000104, "b2b", 1'b1, 12'hF41, 17);
    bus.start = 1'b1;
    bus.value = 32'h000003FC;
    tick;
    bus.start = 1'b0;
    tick;
    tick;
    bus.start = 1'b1;
    bus.value = 32'h000000FF;
    tick;
    bus.start = 1'b0;
    k = 4;
    while (bus.done !== 1'b1 && k < 30) begin
      tick;
      k++;
    end
    chk("abuse latency", k, 17);
    chk("abuse enc", bus.enc, 12'hFFF);
    bus.start = 1'b1;
    bus.value = 32'hFF000000;
    tick;
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold busy", bus.busy, 0);
      chk("hold done", bus.done, 0);
      chk("hold ok", bus.ok, 1);
      chk("hold enc", bus.enc, 12'hFFF);
      tick;
    end
    bus.start = 1'b1;
    bus.value = 32'h00000102;
    tick;
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort no_done", bus.done, 0);
      tick;
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("abort busy", bus.busy, 0);
    chk("abort done", bus.done, 0);
    chk("abort ok", bus.ok, 0);
    chk("abort enc", bus.enc, 0);
    tick;
    chk("abort idle done", bus.done, 0);
    chk("abort idle busy", bus.busy, 0);
    run(32'h000000FF, "after_abort", 1'b1, 12'h0FF, 2);
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) begin
        t = {2{24'b0, 8'($urandom_range(0, 255))}} >> (2 * $urandom_range(0, 15));
        val = t[31:0];
      end else val = $urandom;
      model(val, eok, eenc, elat);
      run(val, "rand", eok, eenc, elat);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/imm_rot_encoder.md
# imm_rot_encoder

Iterative encoder that converts a 32-bit constant into the 12-bit rotated-immediate operand field {rot[3:0], imm8[7:0]} of a data-processing instruction, where the decoded value is imm8 rotated right by 2×rot. It is the inverse of the operand-2 shift/rotate datapath in front of the ALU. Assembler-assist and self-test logic use it to decide whether a constant fits the immediate form, and to produce the bit field if it does. The search covers one rotation per cycle under a start/done handshake.

## Interface
Parameters: none (field widths are fixed by the instruction format).

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- value  input  32  constant to encode; sampled on the accepting edge only
- busy  output  1  high in SEARCH and DONE
- done  output  1  one-cycle pulse, high only in DONE
- ok  output  1  1 = encodable; valid while done is high and held until the next accepted start
- enc  output  12  {rot, imm8}; valid and held like ok; 12'h000 when ok=0

## Operation
- States: IDLE, SEARCH, DONE. Reset forces IDLE, rot=0, busy=0, done=0, ok=0, enc=12'h000, latched value=0.
- IDLE: if start=1, latch value into v, set rot=0, go to SEARCH. Otherwise stay in IDLE.
- SEARCH: each cycle, compute the candidate c = ROL(v, 2×rot) with 32-bit wrap-around; the shift amount is 0..30, even values only. Test: c[31:8]==0.
  - Match: ok←1, enc←{rot, c[7:0]}, go to DONE.
  - No match, rot<15: rot←rot+1, stay in SEARCH.
  - No match, rot==15: ok←0, enc←0, go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- The smallest matching rot wins. value=0 encodes as rot=0, imm8=0, ok=1.
- Identity: for ok=1, ROR({24'b0, enc[7:0]}, 2×enc[11:8]) == v must hold. Verification checks this as an assertion.
- start is ignored in SEARCH and DONE; there is no queueing. value changes after the accepting edge have no effect.
- ok and enc are updated only on the edge entering DONE and hold through IDLE until the next result.
- reset has priority over every transition. Reset mid-SEARCH aborts the search, does not produce a done pulse, and clears ok and enc.

## Timing
- start is high in cycle N (accepted on the edge ending N). The rot=0 test runs in cycle N+1.
- Match at rotation r: done=1 in cycle N+2+r. Best case is N+2; worst-case match is N+17.
- No match: done=1 in cycle N+17, after 16 SEARCH cycles.
- busy is high from cycle N+1 through the DONE cycle inclusive. It is low the cycle after done.
- Back-to-back operation: the earliest next accepting cycle is the one immediately after DONE. Throughput is at best one result per 3 cycles.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.

## Test plan
- Reset then idle: hold reset for 2 cycles with start=1 → busy=0, done=0, ok=0, enc=0x000 throughout, and no search starts while reset is high.
- Direct fit and zero: value=0x000000FF, start in cycle N → done in N+2, ok=1, enc=0x0FF. Then value=0x00000000 → ok=1, enc=0x000, done 2 cycles after start.
- Rotated fits:
  - value=0xFF000000 → enc=0x4FF, done at N+6.
  - value=0xF000000F → enc=0x2FF, done at N+4.
  - value=0x000003FC → enc=0xFFF (rot=15, imm8=0xFF), done at N+17.
- Unencodable: value=0x00000102 → ok=0, enc=0x000, done at N+17, busy low at N+18. Follow with value=0x00000104, started at N+18 → enc=0xF41, ok=1.
- Handshake abuse: pulse start with a different value during SEARCH and during DONE → both ignored, and the result matches the first value. ok and enc hold unchanged for 5 idle cycles after done.
- Reset mid-operation: start value=0x00000102, assert reset at N+5 for one cycle → IDLE at N+6, with busy=0, ok=0, enc=0, and no done pulse. A new start at N+7 with 0xFF → done at N+9, enc=0x0FF.
